// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between scalar MEM-stage accesses and strided vector bursts
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              s_req_i,
    input  logic              s_we_i,
    input  logic [ADDR_W-1:0] s_addr_i,
    input  logic [DATA_W-1:0] s_wdata_i,
    output logic [DATA_W-1:0] s_rdata_o,
    output logic              s_stall_o,
    input  logic              v_req_i,
    input  logic              v_we_i,
    input  logic [ADDR_W-1:0] v_base_i,
    input  logic [ADDR_W-1:0] v_stride_i,
    input  logic [LEN_W-1:0]  v_len_i,
    output logic              v_ack_o,
    output logic [LEN_W-1:0]  v_idx_o,
    input  logic [DATA_W-1:0] v_wdata_i,
    output logic [DATA_W-1:0] v_rdata_o,
    output logic              v_rvalid_o,
    output logic              v_done_o,
    output logic              m_re_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i
);
    typedef enum logic [1:0] {IDLE, VBURST, VDONE} state_e;

    state_e              state_q, state_d;
    logic                prio_q, prio_d;
    logic                we_q, we_d;
    logic [LEN_W-1:0]    idx_q, idx_d, len_q, len_d, len_c;
    logic [ADDR_W-1:0]   addr_q, addr_d, stride_q, stride_d;
    logic                v_win, s_win;

    assign len_c = (v_len_i > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : v_len_i;
    assign v_win = (state_q == IDLE) && v_req_i && (!s_req_i || prio_q);
    assign s_win = (state_q == IDLE) && s_req_i && !v_win;

    // next-state: arbitration in IDLE, element stepping in VBURST, one-cycle completion in VDONE
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        we_d     = we_q;
        idx_d    = idx_q;
        len_d    = len_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        case (state_q)
            IDLE: begin
                if (v_win) begin
                    prio_d   = 1'b0;
                    we_d     = v_we_i;
                    addr_d   = v_base_i;
                    stride_d = v_stride_i;
                    len_d    = len_c;
                    idx_d    = '0;
                    state_d  = (len_c == '0) ? VDONE : VBURST;
                end else if (s_win && v_req_i) begin
                    prio_d = 1'b1;
                end
            end
            VBURST: begin
                addr_d  = addr_q + stride_q;
                idx_d   = idx_q + LEN_W'(1);
                state_d = (idx_q == len_q - LEN_W'(1)) ? VDONE : VBURST;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and latched burst operands
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            stride_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            we_q     <= we_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end

    // bus steering; everything is forced low while reset is held so a write cannot leak mid-burst
    always_comb begin
        s_rdata_o  = '0;
        s_stall_o  = 1'b0;
        v_ack_o    = 1'b0;
        v_idx_o    = '0;
        v_rdata_o  = '0;
        v_rvalid_o = 1'b0;
        v_done_o   = 1'b0;
        m_re_o     = 1'b0;
        m_we_o     = 1'b0;
        m_addr_o   = '0;
        m_wdata_o  = '0;
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    v_ack_o   = v_win;
                    s_stall_o = v_win && s_req_i;
                    if (s_win) begin
                        m_re_o    = !s_we_i;
                        m_we_o    = s_we_i;
                        m_addr_o  = s_addr_i;
                        m_wdata_o = s_wdata_i;
                        s_rdata_o = m_rdata_i;
                    end
                end
                VBURST: begin
                    s_stall_o  = s_req_i;
                    v_idx_o    = idx_q;
                    m_addr_o   = addr_q;
                    m_re_o     = !we_q;
                    m_we_o     = we_q;
                    m_wdata_o  = we_q ? v_wdata_i : '0;
                    v_rvalid_o = !we_q;
                    v_rdata_o  = we_q ? '0 : m_rdata_i;
                end
                VDONE: begin
                    s_stall_o = s_req_i;
                    v_done_o  = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
